val2_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared Val2 generator. Pipeline clients (EXE-stage ALU operand path, requester 0; memory address-offset path, requester 1) submit shift-operand jobs over valid/ready. The block grants one job at a time, drives the generator's operand inputs from registers, and captures `val_2` into a held response buffer with backpressure. It sits between the requesters and the combinational Val2 generator instance in the execute stage.

---
 rtl/val2_arbiter_if.sv | 59 +++++
 rtl/val2_arbiter.sv | 132 +++++++++++++
 tb/tb_val2_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/val2_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : val2_arbiter_if
// Brief   : Bundle of requester, generator and response signals for the
//           Val2 arbiter. "slave" is the arbiter's view; "master" is the view
//           of the surrounding pipeline (requesters, generator, consumer).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface val2_arbiter_if;
  // Requester 0 (EXE ALU operand path)
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_rm;
  logic [11:0] req0_shift_operand;
  logic        req0_imm;
  logic        req0_select;
  // Requester 1 (memory address-offset path)
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_rm;
  logic [11:0] req1_shift_operand;
  logic        req1_imm;
  logic        req1_select;
  // Generator operands and result
  logic [31:0] gen_rm;
  logic [11:0] gen_shift_operand;
  logic        gen_imm;
  logic        gen_select;
  logic [31:0] gen_val_2;
  // Response buffer
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_val_2;
  logic        rsp_id;
  logic        busy;

  modport slave (
    input  req0_valid, req0_rm, req0_shift_operand, req0_imm, req0_select,
    input  req1_valid, req1_rm, req1_shift_operand, req1_imm, req1_select,
    output req0_ready, req1_ready,
    output gen_rm, gen_shift_operand, gen_imm, gen_select,
    input  gen_val_2,
    output rsp_valid, rsp_val_2, rsp_id, busy,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_rm, req0_shift_operand, req0_imm, req0_select,
    output req1_valid, req1_rm, req1_shift_operand, req1_imm, req1_select,
    input  req0_ready, req1_ready,
    input  gen_rm, gen_shift_operand, gen_imm, gen_select,
    output gen_val_2,
    input  rsp_valid, rsp_val_2, rsp_id, busy,
    output rsp_ready
  );
endinterface

`default_nettype wire

// File: rtl/val2_arbiter.sv
//------------------------------------------------------------------------------
// Module  : val2_arbiter
// Brief   : Two-port arbiter/sequencer for the shared Val2 generator. Grants
//           one job at a time, drives the generator from registers, captures
//           its result into a held response buffer with backpressure.
//           Define VAL2_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
//           otherwise requester 0 always wins ties.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module val2_arbiter (
  input  wire logic      clk,
  input  wire logic      rst,   // asynchronous, active-low
  val2_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last_grant;
  logic        r_job_id;
  logic [31:0] r_gen_rm;
  logic [11:0] r_gen_shift_operand;
  logic        r_gen_imm;
  logic        r_gen_select;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_val_2;
  logic        r_rsp_id;

  logic        w_can_accept;
  logic        w_win;
  logic        w_accept;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_tie_pick;

  // Tie-break choice: alternate against the last grant, or fixed to requester 0
  always_comb begin
`ifdef VAL2_ARB_ROUND_ROBIN_EN
    w_tie_pick = ~r_last_grant;
`else
    w_tie_pick = 1'b0;
`endif
  end

  // Acceptance window, winner selection and per-requester ready; ready is
  // held low while in reset so nothing looks accepted before release
  always_comb begin
    w_can_accept = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.rsp_ready);
    if (bus.req0_valid && bus.req1_valid) begin
      w_win = w_tie_pick;
    end else begin
      w_win = ~bus.req0_valid;
    end
    w_accept = rst && w_can_accept && (bus.req0_valid || bus.req1_valid);
    w_ready0 = w_accept && !w_win;
    w_ready1 = w_accept &&  w_win;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a retiring HOLD may chain straight into the next ISSUE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.rsp_ready) w_state_nxt = w_accept ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand load on accept, result capture in ISSUE, retire on rsp_ready in HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant        <= 1'b1;
      r_job_id            <= 1'b0;
      r_gen_rm            <= 32'd0;
      r_gen_shift_operand <= 12'd0;
      r_gen_imm           <= 1'b0;
      r_gen_select        <= 1'b0;
      r_rsp_valid         <= 1'b0;
      r_rsp_val_2         <= 32'd0;
      r_rsp_id            <= 1'b0;
    end else begin
      // Tracked in both arbitration modes; only round-robin consults it
      r_last_grant <= w_accept ? w_win : r_last_grant;
      if (w_accept) begin
        r_job_id            <= w_win;
        r_gen_rm            <= w_win ? bus.req1_rm            : bus.req0_rm;
        r_gen_shift_operand <= w_win ? bus.req1_shift_operand : bus.req0_shift_operand;
        r_gen_imm           <= w_win ? bus.req1_imm           : bus.req0_imm;
        r_gen_select        <= w_win ? bus.req1_select        : bus.req0_select;
      end
      if (r_state == S_ISSUE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_val_2 <= bus.gen_val_2;
        r_rsp_id    <= r_job_id;
      end else if ((r_state == S_HOLD) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req0_ready        = w_ready0;
  assign bus.req1_ready        = w_ready1;
  assign bus.gen_rm            = r_gen_rm;
  assign bus.gen_shift_operand = r_gen_shift_operand;
  assign bus.gen_imm           = r_gen_imm;
  assign bus.gen_select        = r_gen_select;
  assign bus.rsp_valid         = r_rsp_valid;
  assign bus.rsp_val_2         = r_rsp_val_2;
  assign bus.rsp_id            = r_rsp_id;
  assign bus.busy              = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_val2_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_val2_arbiter
// Brief   : Self-checking bench for val2_arbiter. A behavioural Val2 generator
//           feeds gen_val_2; a job-level reference model predicts ready,
//           response and busy each cycle. Honors VAL2_ARB_ROUND_ROBIN_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_val2_arbiter;

`ifdef VAL2_ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk;
  logic rst;

  val2_arbiter_if u_if ();

  val2_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM shifter-operand semantics: 12-bit offset, rotated imm8, or shifted Rm
  function automatic logic [31:0] val2_ref(input logic [31:0] rm, input logic [11:0] so,
                                           input logic imm, input logic sel);
    logic [63:0] dbl;
    logic [63:0] rot;
    int          amt;
    if (sel) return {20'd0, so};
    if (imm) begin
      amt = 2 * int'(so[11:8]);
      dbl = {24'd0, so[7:0], 24'd0, so[7:0]};
      rot = dbl >> amt;
      return rot[31:0];
    end
    amt = int'(so[11:7]);
    case (so[6:5])
      2'd0:    return rm << amt;
      2'd1:    return rm >> amt;
      2'd2:    return 32'($signed(rm) >>> amt);
      default: begin
        dbl = {rm, rm};
        rot = dbl >> amt;
        return rot[31:0];
      end
    endcase
  endfunction

  assign u_if.gen_val_2 = val2_ref(u_if.gen_rm, u_if.gen_shift_operand, u_if.gen_imm, u_if.gen_select);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
  endtask

  // Reference model: at most one job in flight; visible once issued
  logic        m_have;
  logic        m_vis;
  logic        m_last;
  logic [31:0] m_val;
  logic        m_id;
  int          mode;      // 0: drop valid on accept, 1: keep valid, 2: random
  logic        ret_ids[$];

  task automatic model_reset();
    m_have = 1'b0;
    m_vis  = 1'b0;
    m_last = 1'b1;
    m_val  = 32'd0;
    m_id   = 1'b0;
  endtask

  task automatic rand_req(input int n);
    if (n == 0) begin
      u_if.req0_rm            = $urandom;
      u_if.req0_shift_operand = 12'($urandom_range(0, 4095));
      u_if.req0_imm           = 1'($urandom_range(0, 1));
      u_if.req0_select        = 1'($urandom_range(0, 1));
    end else begin
      u_if.req1_rm            = $urandom;
      u_if.req1_shift_operand = 12'($urandom_range(0, 4095));
      u_if.req1_imm           = 1'($urandom_range(0, 1));
      u_if.req1_select        = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock cycle: predict and check at negedge, advance model at posedge,
  // then let the requesters react to what they were granted
  task automatic step();
    logic v0, v1, rr, e_vis, e_can, e_win, e_acc, e_r0, e_r1;
    logic [31:0] p_val;
    @(negedge clk);
    v0    = u_if.req0_valid;
    v1    = u_if.req1_valid;
    rr    = u_if.rsp_ready;
    e_vis = m_have && m_vis;
    e_can = !m_have || (e_vis && rr);
    if (v0 && v1) e_win = RR_MODE ? (m_last == 1'b0) : 1'b0;
    else          e_win = !v0;
    e_acc = e_can && (v0 || v1);
    e_r0  = e_acc && !e_win;
    e_r1  = e_acc && e_win;
    p_val = e_win ? val2_ref(u_if.req1_rm, u_if.req1_shift_operand, u_if.req1_imm, u_if.req1_select)
                  : val2_ref(u_if.req0_rm, u_if.req0_shift_operand, u_if.req0_imm, u_if.req0_select);
    check_val("req0_ready", u_if.req0_ready, e_r0);
    check_val("req1_ready", u_if.req1_ready, e_r1);
    check_val("rsp_valid",  u_if.rsp_valid,  e_vis);
    check_val("busy",       u_if.busy,       m_have);
    if (e_vis) begin
      check_val("rsp_val_2", u_if.rsp_val_2, m_val);
      check_val("rsp_id",    u_if.rsp_id,    m_id);
    end
    if (u_if.rsp_valid && rr) ret_ids.push_back(u_if.rsp_id);
    @(posedge clk);
    if (e_vis && rr)          m_have = 1'b0;
    else if (m_have && !m_vis) m_vis = 1'b1;
    if (e_acc) begin
      m_have = 1'b1;
      m_vis  = 1'b0;
      m_val  = p_val;
      m_id   = e_win;
      m_last = e_win;
    end
    #1;
    if (mode == 2) begin
      if (e_r0 || !u_if.req0_valid) begin rand_req(0); u_if.req0_valid = 1'($urandom_range(0, 1)); end
      if (e_r1 || !u_if.req1_valid) begin rand_req(1); u_if.req1_valid = 1'($urandom_range(0, 1)); end
      u_if.rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      if (e_r0) begin if (mode == 1) rand_req(0); else u_if.req0_valid = 1'b0; end
      if (e_r1) begin if (mode == 1) rand_req(1); else u_if.req1_valid = 1'b0; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req0_ready"}, u_if.req0_ready, 1'b0);
    check_val({tag, "_req1_ready"}, u_if.req1_ready, 1'b0);
    check_val({tag, "_rsp_valid"},  u_if.rsp_valid,  1'b0);
    check_val({tag, "_rsp_val_2"},  u_if.rsp_val_2,  32'd0);
    check_val({tag, "_rsp_id"},     u_if.rsp_id,     1'b0);
    check_val({tag, "_busy"},       u_if.busy,       1'b0);
    check_val({tag, "_gen_rm"},     u_if.gen_rm,     32'd0);
    check_val({tag, "_gen_so"},     u_if.gen_shift_operand, 12'd0);
    check_val({tag, "_gen_ctl"},    {u_if.gen_imm, u_if.gen_select}, 2'd0);
  endtask

  task automatic drain();
    mode = 0;
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
    u_if.rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    model_reset();
    mode = 0;
    rst  = 1'b0;
    rand_req(0);
    rand_req(1);
    u_if.req0_valid = 1'b1;
    u_if.req1_valid = 1'b1;
    u_if.rsp_ready  = 1'b1;

    // Power-on reset with requests pending: nothing may be granted
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Requester 0 alone, rotated immediate
    u_if.req0_rm = 32'h1234_5678; u_if.req0_shift_operand = 12'h2FF;
    u_if.req0_imm = 1'b1; u_if.req0_select = 1'b0; u_if.req0_valid = 1'b1;
    step();
    step();
    check_val("t1_val", u_if.rsp_val_2, 32'hF000_000F);
    check_val("t1_id",  u_if.rsp_id,    1'b0);
    step();

    // Requester 1 alone, 12-bit offset
    u_if.req1_rm = 32'hDEAD_BEEF; u_if.req1_shift_operand = 12'hABC;
    u_if.req1_imm = 1'b1; u_if.req1_select = 1'b1; u_if.req1_valid = 1'b1;
    step();
    step();
    check_val("t2_val", u_if.rsp_val_2, 32'h0000_0ABC);
    check_val("t2_id",  u_if.rsp_id,    1'b1);
    step();

    // Both requesters continuously valid, consumer always ready
    mode = 1;
    ret_ids.delete();
    rand_req(0); rand_req(1);
    u_if.req0_valid = 1'b1; u_if.req1_valid = 1'b1; u_if.rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check_val("t3_count", ret_ids.size(), 4);
    for (int i = 0; i < 4 && i < ret_ids.size(); i++)
      check_val($sformatf("t3_id%0d", i), ret_ids[i], RR_MODE ? 1'(i % 2) : 1'b0);
    // Requester 0 drops out; requester 1 must then be served
    mode = 0;
    for (int i = 0; i < 6; i++) step();
    drain();

    // Backpressure: held response stays put, no grants; retire overlaps accept
    u_if.req0_rm = 32'h1; u_if.req0_shift_operand = 12'h200;
    u_if.req0_imm = 1'b0; u_if.req0_select = 1'b0; u_if.req0_valid = 1'b1;
    u_if.rsp_ready = 1'b0;
    step();
    rand_req(1);
    u_if.req1_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t4_hold_val", u_if.rsp_val_2, 32'h10);
    end
    u_if.rsp_ready = 1'b1;
    step();
    check_val("t4_busy_after_retire", u_if.busy, 1'b1);
    drain();

    // Randomized traffic
    mode = 2;
    for (int i = 0; i < 400; i++) step();
    drain();

    // Reset while a job is in ISSUE: job dropped, outputs return to reset
    rand_req(0);
    u_if.req0_valid = 1'b1;
    step();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rand_req(0); rand_req(1);
    u_if.req0_valid = 1'b1; u_if.req1_valid = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
